// File: rtl/decode_hazard_unit_if.sv
// Decode-stage hazard bus: the instruction in decode, the bypass channels,
// the writeback port, flush, and the resolved-operand / hazard results.
interface decode_hazard_unit_if #(
    parameter int ARCH_LEN     = 32,
    parameter int REG_FILE_LEN = 32,
    parameter int NUM_BYP      = 3,
    parameter int CNT_W        = 32
);
    localparam int RW = $clog2(REG_FILE_LEN);

    // instruction in decode
    logic                         dec_valid_in;
    logic [RW-1:0]                src_reg_1_in;
    logic [RW-1:0]                src_reg_2_in;
    logic [RW-1:0]                dst_reg_in;
    logic                         uses_src1_in;
    logic                         uses_src2_in;
    logic                         writes_dst_in;
    logic                         issue_ready_in;

    // bypass channels, channel 0 youngest
    logic [NUM_BYP-1:0]           byp_valid_in;
    logic [NUM_BYP-1:0]           byp_we_in;
    logic [NUM_BYP-1:0]           byp_ready_in;
    logic [NUM_BYP*RW-1:0]        byp_dst_in;
    logic [NUM_BYP*ARCH_LEN-1:0]  byp_data_in;

    // writeback and flush
    logic                         wb_valid_in;
    logic [RW-1:0]                wb_dst_in;
    logic [ARCH_LEN-1:0]          wb_data_in;
    logic                         flush_in;

    // results
    logic                         issue_out;
    logic                         stall_out;
    logic [ARCH_LEN-1:0]          src_data_1_out;
    logic [ARCH_LEN-1:0]          src_data_2_out;
    logic [REG_FILE_LEN-1:0]      busy_vec_out;
    logic [CNT_W-1:0]             stall_cnt_out;

    modport master (
        output dec_valid_in, src_reg_1_in, src_reg_2_in, dst_reg_in,
               uses_src1_in, uses_src2_in, writes_dst_in, issue_ready_in,
               byp_valid_in, byp_we_in, byp_ready_in, byp_dst_in, byp_data_in,
               wb_valid_in, wb_dst_in, wb_data_in, flush_in,
        input  issue_out, stall_out, src_data_1_out, src_data_2_out,
               busy_vec_out, stall_cnt_out
    );

    modport slave (
        input  dec_valid_in, src_reg_1_in, src_reg_2_in, dst_reg_in,
               uses_src1_in, uses_src2_in, writes_dst_in, issue_ready_in,
               byp_valid_in, byp_we_in, byp_ready_in, byp_dst_in, byp_data_in,
               wb_valid_in, wb_dst_in, wb_data_in, flush_in,
        output issue_out, stall_out, src_data_1_out, src_data_2_out,
               busy_vec_out, stall_cnt_out
    );
endinterface

// File: rtl/decode_hazard_unit.sv
// Decode-stage operand resolution and hazard unit: architectural register
// file, per-register scoreboard of in-flight writers, priority bypass from
// NUM_BYP downstream channels, WAW protection, flush and a stall counter.
module decode_hazard_unit #(
    parameter int ARCH_LEN     = 32,
    parameter int REG_FILE_LEN = 32,
    parameter int NUM_BYP      = 3,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    decode_hazard_unit_if.slave  bus
);
    localparam int RW = $clog2(REG_FILE_LEN);

    logic [ARCH_LEN-1:0]     regs [REG_FILE_LEN];
    logic [REG_FILE_LEN-1:0] busy;
    logic [REG_FILE_LEN-1:0] busy_next;
    logic [CNT_W-1:0]        stall_cnt;

    logic [1:0]              op_use;
    logic [RW-1:0]           op_reg  [2];
    logic [ARCH_LEN-1:0]     op_data [2];
    logic [1:0]              op_unres;

    logic                    waw;
    logic                    stall;
    logic                    issue;

    assign op_use    = {bus.uses_src2_in, bus.uses_src1_in};
    assign op_reg[0] = bus.src_reg_1_in;
    assign op_reg[1] = bus.src_reg_2_in;

    // Resolve both operands: youngest matching bypass channel, then writeback
    // write-through, then scoreboard, then the register file.
    always_comb begin : resolve
        logic matched;
        for (int k = 0; k < 2; k++) begin
            // NOTE: every combinational output gets a default first so no
            // path leaves it unassigned, which would infer a latch.
            op_data[k]  = regs[op_reg[k]];
            op_unres[k] = 1'b0;
            matched     = 1'b0;
            if (op_use[k] && op_reg[k] != '0) begin
                for (int i = 0; i < NUM_BYP; i++) begin
                    if (!matched && bus.byp_valid_in[i] && bus.byp_we_in[i] &&
                        bus.byp_dst_in[i*RW +: RW] == op_reg[k]) begin
                        matched = 1'b1;
                        if (bus.byp_ready_in[i])
                            op_data[k] = bus.byp_data_in[i*ARCH_LEN +: ARCH_LEN];
                        else
                            op_unres[k] = 1'b1;
                    end
                end
                if (!matched) begin
                    if (bus.wb_valid_in && bus.wb_dst_in == op_reg[k])
                        op_data[k] = bus.wb_data_in;
                    else if (busy[op_reg[k]])
                        op_unres[k] = 1'b1;
                end
            end
        end
    end

    // Hazard detection and issue decision for the instruction in decode.
    always_comb begin : hazard
        waw   = bus.writes_dst_in && bus.dst_reg_in != '0 && busy[bus.dst_reg_in] &&
                !(bus.wb_valid_in && bus.wb_dst_in == bus.dst_reg_in);
        stall = bus.dec_valid_in && !bus.flush_in && (op_unres[0] || op_unres[1] || waw);
        issue = bus.dec_valid_in && !bus.flush_in && !stall && bus.issue_ready_in;
    end

    // Next scoreboard: writeback clears, issue sets afterwards so set wins.
    always_comb begin : scoreboard_next
        // NOTE: combinational intermediates use blocking assignment so the
        // later set overrides the earlier clear within this evaluation.
        busy_next = busy;
        if (bus.wb_valid_in && bus.wb_dst_in != '0)
            busy_next[bus.wb_dst_in] = 1'b0;
        if (issue && bus.writes_dst_in && bus.dst_reg_in != '0)
            busy_next[bus.dst_reg_in] = 1'b1;
        if (bus.flush_in)
            busy_next = '0;
    end

    // Register file: writeback port, x0 hard-wired to zero.
    always_ff @(posedge clk) begin : reg_file
        // NOTE: the array is reset because architectural registers must read
        // zero after reset; a plain storage array would normally skip this.
        if (!rst) begin
            for (int r = 0; r < REG_FILE_LEN; r++)
                regs[r] <= '0;
        end else if (bus.wb_valid_in && bus.wb_dst_in != '0) begin
            regs[bus.wb_dst_in] <= bus.wb_data_in;
        end
    end

    // Scoreboard and saturating stall counter state.
    always_ff @(posedge clk) begin : state
        if (!rst) begin
            busy      <= '0;
            stall_cnt <= '0;
        end else begin
            busy <= busy_next;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.src_data_1_out = op_data[0];
    assign bus.src_data_2_out = op_data[1];
    assign bus.stall_out      = stall;
    assign bus.issue_out      = issue;
    assign bus.busy_vec_out   = busy;
    assign bus.stall_cnt_out  = stall_cnt;
endmodule

// File: tb/tb_decode_hazard_unit.sv
// Bench for decode_hazard_unit: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the register file, scoreboard
// and stall counter. Counter width is reduced so saturation is reachable.
module tb_decode_hazard_unit;
    localparam int AL  = 32;
    localparam int NR  = 32;
    localparam int NB  = 3;
    localparam int CW  = 4;
    localparam int RWB = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_hazard_unit_if #(.ARCH_LEN(AL), .REG_FILE_LEN(NR), .NUM_BYP(NB), .CNT_W(CW)) bus ();

    decode_hazard_unit #(.ARCH_LEN(AL), .REG_FILE_LEN(NR), .NUM_BYP(NB), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // stimulus state
    logic           dv, u1, u2, wd, irdy, wbv, flush;
    logic [RWB-1:0] s1, s2, dst, wbdst;
    logic [AL-1:0]  wbdata;
    logic           ch_v [NB];
    logic           ch_we [NB];
    logic           ch_rdy [NB];
    logic [RWB-1:0] ch_dst [NB];
    logic [AL-1:0]  ch_data [NB];

    // model state
    logic [AL-1:0]  m_regs [NR];
    logic [NR-1:0]  m_busy;
    int             m_cnt;

    // model expectations for the current cycle
    logic [AL-1:0]  e_d1, e_d2;
    bit             e_u1, e_u2, e_stall, e_issue;

    int checks = 0;
    int errors = 0;

    task automatic clear_inputs();
        dv = 0; u1 = 0; u2 = 0; wd = 0; irdy = 1; wbv = 0; flush = 0;
        s1 = 0; s2 = 0; dst = 0; wbdst = 0; wbdata = 0;
        for (int i = 0; i < NB; i++) begin
            ch_v[i] = 0; ch_we[i] = 0; ch_rdy[i] = 0; ch_dst[i] = 0; ch_data[i] = 0;
        end
    endtask

    task automatic drive();
        bus.dec_valid_in   = dv;
        bus.src_reg_1_in   = s1;
        bus.src_reg_2_in   = s2;
        bus.dst_reg_in     = dst;
        bus.uses_src1_in   = u1;
        bus.uses_src2_in   = u2;
        bus.writes_dst_in  = wd;
        bus.issue_ready_in = irdy;
        bus.wb_valid_in    = wbv;
        bus.wb_dst_in      = wbdst;
        bus.wb_data_in     = wbdata;
        bus.flush_in       = flush;
        for (int i = 0; i < NB; i++) begin
            bus.byp_valid_in[i]          = ch_v[i];
            bus.byp_we_in[i]             = ch_we[i];
            bus.byp_ready_in[i]          = ch_rdy[i];
            bus.byp_dst_in[i*RWB +: RWB] = ch_dst[i];
            bus.byp_data_in[i*AL +: AL]  = ch_data[i];
        end
    endtask

    // One operand by the resolution rules: collect all matching channels,
    // the first collected (youngest) decides.
    task automatic ref_operand(input bit use_it, input logic [RWB-1:0] r,
                               output logic [AL-1:0] d, output bit unres);
        int hits[$];
        d = m_regs[r];
        unres = 0;
        if (use_it && r != 0) begin
            for (int c = 0; c < NB; c++)
                if (ch_v[c] && ch_we[c] && ch_dst[c] == r) hits.push_back(c);
            if (hits.size() > 0) begin
                if (ch_rdy[hits[0]]) d = ch_data[hits[0]];
                else unres = 1;
            end else if (wbv && wbdst == r) begin
                d = wbdata;
            end else if (m_busy[r]) begin
                unres = 1;
            end
        end
    endtask

    task automatic model_eval();
        bit waw;
        ref_operand(u1, s1, e_d1, e_u1);
        ref_operand(u2, s2, e_d2, e_u2);
        waw = wd && dst != 0 && m_busy[dst] && !(wbv && wbdst == dst);
        e_stall = dv && !flush && (e_u1 || e_u2 || waw);
        e_issue = dv && !flush && !e_stall && irdy;
    endtask

    // Apply inputs and let the combinational outputs settle.
    task automatic settle();
        drive();
        #1;
        model_eval();
    endtask

    // Advance the model across one rising edge, then the clock itself.
    task automatic tick();
        drive();
        model_eval();
        if (!rst) begin
            for (int r = 0; r < NR; r++) m_regs[r] = 0;
            m_busy = 0;
            m_cnt  = 0;
        end else begin
            if (wbv && wbdst != 0) m_regs[wbdst] = wbdata;
            if (flush) m_busy = 0;
            else begin
                if (wbv && wbdst != 0) m_busy[wbdst] = 1'b0;
                if (e_issue && wd && dst != 0) m_busy[dst] = 1'b1;
            end
            if (e_stall && m_cnt < (1 << CW) - 1) m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 0;
        clear_inputs();
        tick();
        tick();
        rst = 1;
        settle();
        checks++; if (bus.issue_out !== 1'b0) begin errors++; $display("FAIL reset_issue act=%b exp=0", bus.issue_out); end
        checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall act=%b exp=0", bus.stall_out); end
        checks++; if (bus.busy_vec_out !== '0) begin errors++; $display("FAIL reset_busy act=%h exp=0", bus.busy_vec_out); end
        checks++; if (bus.stall_cnt_out !== '0) begin errors++; $display("FAIL reset_cnt act=%0d exp=0", bus.stall_cnt_out); end
    endtask

    task automatic test_bypass_priority();
        clear_inputs();
        ch_v[0] = 1; ch_we[0] = 1; ch_rdy[0] = 1; ch_dst[0] = 5; ch_data[0] = 32'hAAAA;
        ch_v[1] = 1; ch_we[1] = 1; ch_rdy[1] = 1; ch_dst[1] = 5; ch_data[1] = 32'hBBBB;
        dv = 1; u1 = 1; s1 = 5;
        settle();
        checks++; if (bus.src_data_1_out !== e_d1) begin errors++; $display("FAIL byp_prio_data act=%h exp=%h", bus.src_data_1_out, e_d1); end
        checks++; if (bus.stall_out !== e_stall) begin errors++; $display("FAIL byp_prio_stall act=%b exp=%b", bus.stall_out, e_stall); end
        tick();
    endtask

    task automatic test_unready_youngest();
        clear_inputs();
        ch_v[0] = 1; ch_we[0] = 1; ch_rdy[0] = 0; ch_dst[0] = 7; ch_data[0] = 32'h0;
        ch_v[2] = 1; ch_we[2] = 1; ch_rdy[2] = 1; ch_dst[2] = 7; ch_data[2] = 32'h9999;
        dv = 1; u1 = 1; s1 = 7;
        settle();
        checks++; if (bus.stall_out !== e_stall || !e_stall) begin errors++; $display("FAIL unready_stall act=%b exp=%b", bus.stall_out, e_stall); end
        checks++; if (bus.issue_out !== e_issue) begin errors++; $display("FAIL unready_issue act=%b exp=%b", bus.issue_out, e_issue); end
        tick();
        ch_rdy[0] = 1; ch_data[0] = 32'h1234;
        settle();
        checks++; if (bus.src_data_1_out !== e_d1) begin errors++; $display("FAIL unready_data act=%h exp=%h", bus.src_data_1_out, e_d1); end
        checks++; if (bus.issue_out !== e_issue) begin errors++; $display("FAIL unready_issue2 act=%b exp=%b", bus.issue_out, e_issue); end
        checks++; if (bus.stall_cnt_out !== CW'(m_cnt)) begin errors++; $display("FAIL unready_cnt act=%0d exp=%0d", bus.stall_cnt_out, m_cnt); end
        tick();
    endtask

    task automatic test_multicycle();
        clear_inputs();
        dv = 1; wd = 1; dst = 9;
        settle();
        checks++; if (bus.issue_out !== e_issue) begin errors++; $display("FAIL mc_writer_issue act=%b exp=%b", bus.issue_out, e_issue); end
        tick();
        checks++; if (bus.busy_vec_out !== m_busy) begin errors++; $display("FAIL mc_busy_set act=%h exp=%h", bus.busy_vec_out, m_busy); end
        wd = 0; u1 = 1; s1 = 9;
        for (int n = 0; n < 3; n++) begin
            settle();
            checks++; if (bus.stall_out !== e_stall) begin errors++; $display("FAIL mc_consumer_stall act=%b exp=%b", bus.stall_out, e_stall); end
            tick();
        end
        wbv = 1; wbdst = 9; wbdata = 32'h55;
        settle();
        checks++; if (bus.issue_out !== e_issue) begin errors++; $display("FAIL mc_wb_issue act=%b exp=%b", bus.issue_out, e_issue); end
        checks++; if (bus.src_data_1_out !== e_d1) begin errors++; $display("FAIL mc_wb_data act=%h exp=%h", bus.src_data_1_out, e_d1); end
        tick();
        wbv = 0;
        settle();
        checks++; if (bus.busy_vec_out[9] !== 1'b0) begin errors++; $display("FAIL mc_busy_clear act=%b exp=0", bus.busy_vec_out[9]); end
        checks++; if (bus.src_data_1_out !== e_d1) begin errors++; $display("FAIL mc_array_read act=%h exp=%h", bus.src_data_1_out, e_d1); end
        tick();
    endtask

    task automatic test_waw();
        clear_inputs();
        dv = 1; wd = 1; dst = 3;
        tick();
        settle();
        checks++; if (bus.stall_out !== e_stall) begin errors++; $display("FAIL waw_stall act=%b exp=%b", bus.stall_out, e_stall); end
        tick();
        wbv = 1; wbdst = 3; wbdata = 32'h77;
        settle();
        checks++; if (bus.issue_out !== e_issue) begin errors++; $display("FAIL waw_wb_issue act=%b exp=%b", bus.issue_out, e_issue); end
        tick();
        checks++; if (bus.busy_vec_out !== m_busy) begin errors++; $display("FAIL waw_set_wins act=%h exp=%h", bus.busy_vec_out, m_busy); end
        clear_inputs();
        wbv = 1; wbdst = 3; wbdata = 32'h78;
        tick();
    endtask

    task automatic test_x0_flush();
        logic [4:0] targets [8];
        clear_inputs();
        for (int i = 0; i < NB; i++) begin
            ch_v[i] = 1; ch_we[i] = 1; ch_rdy[i] = 0; ch_dst[i] = 0; ch_data[i] = 32'hDEAD0000 + i;
        end
        dv = 1; u1 = 1; s1 = 0;
        settle();
        checks++; if (bus.src_data_1_out !== e_d1) begin errors++; $display("FAIL x0_data act=%h exp=%h", bus.src_data_1_out, e_d1); end
        checks++; if (bus.stall_out !== e_stall) begin errors++; $display("FAIL x0_stall act=%b exp=%b", bus.stall_out, e_stall); end
        tick();
        clear_inputs();
        targets = '{4, 5, 6, 7, 12, 13, 14, 15};
        for (int i = 0; i < 8; i++) begin
            dv = 1; wd = 1; dst = targets[i];
            tick();
        end
        clear_inputs();
        settle();
        checks++; if (bus.busy_vec_out !== m_busy) begin errors++; $display("FAIL flush_pre_busy act=%h exp=%h", bus.busy_vec_out, m_busy); end
        dv = 1; wd = 1; dst = 20; flush = 1;
        wbv = 1; wbdst = 20; wbdata = 32'hCAFE;
        settle();
        checks++; if (bus.issue_out !== e_issue) begin errors++; $display("FAIL flush_issue act=%b exp=%b", bus.issue_out, e_issue); end
        tick();
        clear_inputs();
        dv = 1; u1 = 1; s1 = 20;
        settle();
        checks++; if (bus.busy_vec_out !== m_busy) begin errors++; $display("FAIL flush_busy act=%h exp=%h", bus.busy_vec_out, m_busy); end
        checks++; if (bus.src_data_1_out !== e_d1) begin errors++; $display("FAIL flush_wb_kept act=%h exp=%h", bus.src_data_1_out, e_d1); end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            dv = ($urandom_range(0, 3) != 0);
            u1 = $urandom_range(0, 1); u2 = $urandom_range(0, 1); wd = $urandom_range(0, 1);
            s1 = $urandom_range(0, 7); s2 = $urandom_range(0, 7); dst = $urandom_range(0, 7);
            irdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NB; i++) begin
                ch_v[i] = $urandom_range(0, 1); ch_we[i] = $urandom_range(0, 1);
                ch_rdy[i] = ($urandom_range(0, 3) != 0);
                ch_dst[i] = $urandom_range(0, 7); ch_data[i] = $urandom;
            end
            wbv = ($urandom_range(0, 2) == 0); wbdst = $urandom_range(0, 7); wbdata = $urandom;
            flush = ($urandom_range(0, 19) == 0);
            settle();
            checks++; if (bus.stall_out !== e_stall) begin errors++; $display("FAIL rnd_stall n=%0d act=%b exp=%b", n, bus.stall_out, e_stall); end
            checks++; if (bus.issue_out !== e_issue) begin errors++; $display("FAIL rnd_issue n=%0d act=%b exp=%b", n, bus.issue_out, e_issue); end
            checks++; if (bus.busy_vec_out !== m_busy) begin errors++; $display("FAIL rnd_busy n=%0d act=%h exp=%h", n, bus.busy_vec_out, m_busy); end
            checks++; if (bus.stall_cnt_out !== CW'(m_cnt)) begin errors++; $display("FAIL rnd_cnt n=%0d act=%0d exp=%0d", n, bus.stall_cnt_out, m_cnt); end
            if (!e_u1) begin
                checks++; if (bus.src_data_1_out !== e_d1) begin errors++; $display("FAIL rnd_d1 n=%0d act=%h exp=%h", n, bus.src_data_1_out, e_d1); end
            end
            if (!e_u2) begin
                checks++; if (bus.src_data_2_out !== e_d2) begin errors++; $display("FAIL rnd_d2 n=%0d act=%h exp=%h", n, bus.src_data_2_out, e_d2); end
            end
            tick();
        end
        clear_inputs();
        flush = 1;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        dv = 1; wd = 1; dst = 11; wbv = 1; wbdst = 9; wbdata = 32'h1111;
        tick();
        clear_inputs();
        dv = 1; u1 = 1; s1 = 11;
        tick();
        tick();
        rst = 0;
        tick();
        rst = 1;
        clear_inputs();
        settle();
        checks++; if (bus.busy_vec_out !== '0) begin errors++; $display("FAIL rst_mid_busy act=%h exp=0", bus.busy_vec_out); end
        checks++; if (bus.stall_cnt_out !== '0) begin errors++; $display("FAIL rst_mid_cnt act=%0d exp=0", bus.stall_cnt_out); end
        dv = 1; u1 = 1;
        for (int r = 0; r < NR; r++) begin
            s1 = RWB'(r);
            settle();
            checks++; if (bus.src_data_1_out !== '0) begin errors++; $display("FAIL rst_mid_reg%0d act=%h exp=0", r, bus.src_data_1_out); end
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        clear_inputs();
        dv = 1; wd = 1; dst = 10;
        tick();
        clear_inputs();
        dv = 1; u1 = 1; s1 = 10;
        for (int n = 0; n < 20; n++) begin
            tick();
            checks++; if (bus.stall_cnt_out !== CW'(m_cnt)) begin errors++; $display("FAIL sat_cnt n=%0d act=%0d exp=%0d", n, bus.stall_cnt_out, m_cnt); end
        end
        checks++; if (bus.stall_cnt_out !== 4'hF) begin errors++; $display("FAIL sat_final act=%0d exp=15", bus.stall_cnt_out); end
        clear_inputs();
        wbv = 1; wbdst = 10; wbdata = 32'h5A;
        tick();
        clear_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < NR; r++) m_regs[r] = 0;
        m_busy = 0;
        m_cnt  = 0;
        test_reset();
        test_bypass_priority();
        test_unready_youngest();
        test_multicycle();
        test_waw();
        test_x0_flush();
        test_random();
        test_reset_mid_stall();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_hazard_unit.md
# decode_hazard_unit

Parametrised operand-resolution and hazard unit for the decode stage. It holds the architectural register file, keeps a per-register scoreboard of in-flight writers, forwards operands from up to NUM_BYP downstream bypass channels in priority order, and raises a stall when an operand or destination cannot be resolved this cycle. It replaces the fixed two-source EXE/MEM compare in decode. It adds scoreboard tracking of multi-cycle producers that have left the bypass window, WAW protection, flush, and a stall-cycle counter.

## Interface
- ARCH_LEN, 32, data width
- REG_FILE_LEN, 32, register count; RW = $clog2(REG_FILE_LEN)
- NUM_BYP, 3, bypass channels; channel 0 is the youngest (EXE), higher indices are older
- CNT_W, 32, stall counter width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset
- dec_valid_in  in  1  decode holds a valid instruction
- src_reg_1_in, src_reg_2_in, dst_reg_in  in  RW each  operand and destination indices
- uses_src1_in, uses_src2_in, writes_dst_in  in  1 each  operand and destination usage flags
- issue_ready_in  in  1  EXE can accept an instruction this cycle
- issue_out  out  1  instruction leaves decode this cycle
- stall_out  out  1  decode must hold its instruction
- src_data_1_out, src_data_2_out  out  ARCH_LEN each  resolved operands
- byp_valid_in, byp_we_in, byp_ready_in  in  NUM_BYP each  per-channel bypass flags
- byp_dst_in  in  NUM_BYP*RW  channel i occupies bits [i*RW +: RW]
- byp_data_in  in  NUM_BYP*ARCH_LEN  channel i occupies bits [i*ARCH_LEN +: ARCH_LEN]
- wb_valid_in  in  1  writeback write enable
- wb_dst_in  in  RW  writeback destination
- wb_data_in  in  ARCH_LEN  writeback data
- flush_in  in  1  pipeline flush
- busy_vec_out  out  REG_FILE_LEN  scoreboard state
- stall_cnt_out  out  CNT_W  count of stalled cycles

## Operation
- **Register file.** Writes on wb_valid_in when wb_dst_in≠0. Reads are combinational. x0 always reads 0 and is never marked busy.
- **Operand resolution** (per operand, combinational):
  - If the operand is unused or its register is 0: data is the register-file value (0 for x0), no hazard.
  - Otherwise, search channels 0..NUM_BYP-1. The lowest-index channel with valid & we & dst==reg wins.
  - Winner with ready=1: data comes from that channel's byp_data. Winner with ready=0: operand is unresolved.
  - No channel matches, and wb_valid_in & wb_dst_in==reg: data is wb_data_in (write-through).
  - No channel matches, no writeback match, busy[reg]=1: operand is unresolved (producer is still in flight outside the bypass window).
  - Otherwise: data is the register-file value.
- **WAW hazard.** writes_dst_in & dst≠0 & busy[dst] & ~(wb_valid_in & wb_dst_in==dst).
- **Stall and issue.**
  - stall_out = dec_valid_in & ~flush_in & (unres1 | unres2 | waw).
  - issue_out = dec_valid_in & ~flush_in & ~stall_out & issue_ready_in.
  - A backpressure hold (issue_ready_in=0) is not a stall.
- **Scoreboard update** (edge):
  - Clear busy[wb_dst_in] on writeback.
  - Set busy[dst_reg_in] on issue_out & writes_dst_in & dst≠0.
  - Set and clear on the same register in the same cycle: set wins.
  - flush_in clears every busy bit. The writeback write still happens, and no new issue occurs that cycle.
- **Stall counter.** Increments on each cycle with stall_out=1 and saturates at all-ones.
- **Reset.** All registers 0, busy_vec_out=0, stall_cnt_out=0. issue_out and stall_out are 0 unless dec_valid_in=1.

## Timing
- Resolution, stall_out and issue_out are combinational in the same cycle as the inputs.
- Busy bits change one edge after issue or writeback. An instruction issued in cycle N is visible in busy_vec_out in cycle N+1.
- A writeback in cycle N is forwarded in cycle N and read from the array from N+1.
- A stall persists with no timeout until it is resolved. Operands must be re-evaluated every cycle.
- Reset asserted mid-stall: outputs and state return to reset values at the next edge.

## Test plan
- **Bypass priority.** ch0 and ch1 both write x5, ch0 data=0xAAAA ready, ch1 data=0xBBBB; decode src1=x5 → src_data_1_out=0xAAAA, stall_out=0.
- **Unready youngest.** ch0 matches x7 with ready=0 while ch2 matches x7 ready → stall_out=1. Next cycle ch0 ready with 0x1234 → data 0x1234, issue_out=1, stall_cnt_out=1.
- **Multi-cycle producer.**
  - Issue a writer to x9, then remove it from all channels → consumer of x9 stalls.
  - Writeback x9=0x55 in cycle N → consumer issues in cycle N with 0x55.
  - busy_vec_out[9]=0 at N+1.
- **WAW and simultaneous events.**
  - busy[x3]=1, new writer to x3 → stall.
  - Writeback x3 while a new x3 writer issues the same cycle → busy[3]=1 afterwards.
- **x0 and flush.**
  - src1=x0 while all channels target x0 → data 0, no stall.
  - Flush with busy=0x0000_F0F0 → busy=0 next cycle, issue_out=0 during the flush cycle.
- **Reset.** Drive rst low for one edge mid-stall → busy=0, stall_cnt_out=0, all registers read 0. Also force the counter to all-ones and check it saturates.
